inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
Instruction fetch stage with a direct-mapped, one-word-per-line instruction cache. It sits directly upstream of the decoder and delivers one {PC, instruction} pair per cycle on a cache hit. Misses are filled through a word-wide memory-controller port. The PC is redirected by the decoder (branch/jump target) and by the ROB (mispredict/flush), with the ROB taking priority.

Parameters:
ICACHE_LINES, 64, number of cache lines; power of two, at least 2.
IDX_W, log2(ICACHE_LINES) = 6, index width; the index is pc[IDX_W+1:2].
TAG_W, 30-IDX_W = 24, tag width; the tag is pc[31:IDX_W+2].
RESET_PC, 32'h0, PC loaded on reset.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
rdy  in  1  global enable; when low, all state and outputs hold
inst_valid  out  1  inst_pc/inst_data are valid for the decoder
inst_pc  out  32  address of the presented instruction
inst_data  out  32  presented instruction word
dec_accept  in  1  decoder takes the instruction this cycle
dec_redirect  in  1  decoder redirect request (jal/branch/jalr)
dec_redirect_addr  in  32  decoder redirect target
rob_flush  in  1  ROB flush (mispredict)
rob_flush_addr  in  32  correct PC after flush
mem_req  out  1  word read request to the memory controller
mem_addr  out  32  request address, word aligned
mem_ready  in  1  one-cycle pulse: mem_data is valid
mem_data  in  32  returned word

Behaviour:
- Reset values: pc=RESET_PC, state=RUN, all line valid bits 0, inst_valid=0, inst_pc=0, inst_data=0, mem_req=0, mem_addr=0, stale=0.
- rdy=0 freezes everything; input pulses that arrive in that cycle are ignored.
- Cache lookup is combinational on pc: hit = valid[idx] && tag[idx]==pc tag.
- A "slot free" condition is !inst_valid || dec_accept.
- State RUN, slot free, hit: next cycle inst_valid=1, inst_pc=pc, inst_data=line, pc=pc+4. Back-to-back hits sustain 1 instruction per cycle.
- State RUN, slot free, miss: inst_valid<=0, mem_req<=1, mem_addr<={pc[31:2],2'b00}, state goes to MISS.
- State RUN, slot not free: all outputs hold.
- State MISS: mem_req and mem_addr are held until mem_ready. When mem_ready arrives:
  - write line[idx(mem_addr)] = mem_data with its tag, and set valid.
  - mem_req<=0 and state goes to RUN.
  - If stale=0, also inst_valid=1, inst_pc=mem_addr, inst_data=mem_data, pc=mem_addr+4.
  - If stale=1, the fill is kept but not presented; stale<=0 and pc is unchanged.
- Miss latency: the instruction is valid the cycle after mem_ready. No new request is issued in the cycle mem_ready is seen.
- Redirect (rob_flush takes priority over dec_redirect; both are level-sampled each cycle):
  - pc<=target with bits [1:0] cleared, inst_valid<=0. A dec_accept in the same cycle is irrelevant.
  - If in MISS with no mem_ready this cycle, stale<=1 and the request stays outstanding. The memory controller is never abandoned mid-transaction.
  - If in MISS with mem_ready this same cycle, the fill is written, nothing is presented, state goes to RUN, and pc takes the redirect target.
  - A redirect overrides any hit or miss action in that cycle.
- pc+4 wraps modulo 2^32.
- Aliasing: a fill overwrites the line at the same index unconditionally.
- Lines are never invalidated except on reset; there is no self-modifying-code support.
- Reset mid-miss: mem_req drops immediately (asynchronous). The memory controller must treat a reset as aborting the transaction.

Decomposition:
- Shared const include: ICACHE_LINES default, RESET_PC, and the fetch state encodings (RUN=1'b0, MISS=1'b1).
- One natural sub-module, icache_array:
  - tag/data/valid storage with a combinational read port (index, tag to hit, data) and a synchronous write port.
  - clear-all on rst.
- Fetch control (PC, FSM, redirect, stale) stays in inst_fetch.

Test Plan:
1. Cold start: reset, dec_accept=1, memory returns 32'h00000013 after 3 cycles -> mem_addr=0 is held with mem_req=1 for 3 cycles; the cycle after mem_ready, inst_valid=1, inst_pc=0, inst_data=32'h00000013; the next request is for addr 4.
2. Hit streaming: preload addresses 0..0x1C, then refetch from 0 with dec_accept=1 -> eight consecutive valid cycles, inst_pc 0,4,...,0x1C, with no mem_req.
3. Stall hold: a hit is presented and dec_accept=0 for 4 cycles -> inst_valid/inst_pc/inst_data are stable and pc does not advance.
4. Redirect during miss: miss at 0x100, dec_redirect to 0x40 two cycles before mem_ready -> 0x100 is filled but not presented; the next request or lookup is at 0x40; no instruction from 0x100 appears.
5. Simultaneous redirects: dec_redirect=0x80 and rob_flush=0x200 in the same cycle -> the next presented inst_pc is 0x200.
6. Aliasing and reset: fill 0x0, then 0x100 (same index at 64 lines), then fetch 0x0 -> a miss is reissued. Assert rst during an outstanding miss -> mem_req=0 and inst_valid=0 immediately; after reset, the fetch of 0x0 misses.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared constants for the instruction fetch stage: cache geometry default,
// reset PC and the fetch FSM state encodings.
package inst_fetch_pkg;
    localparam int          ICACHE_LINES = 64;
    localparam logic [31:0] RESET_PC     = 32'h0000_0000;
    localparam logic        ST_RUN       = 1'b0;
    localparam logic        ST_MISS      = 1'b1;
endpackage

// File: rtl/inst_fetch_icache_array.sv
// Direct-mapped, one-word-per-line instruction cache storage.
// Lookup is combinational; fills are written on the clock edge.
module inst_fetch_icache_array #(
    parameter int LINES = 64,
    parameter int IDX_W = 6,
    parameter int TAG_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] i_rd_idx,
    input  logic [TAG_W-1:0] i_rd_tag,
    output logic             o_hit,
    output logic [31:0]      o_rd_data,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [TAG_W-1:0] i_wr_tag,
    input  logic [31:0]      i_wr_data
);
    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [31:0]      r_data [LINES];

    // Only the valid bits need clearing; stale tag/data behind a clear bit never hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_valid <= '0;
        else if (i_wr_en)
            r_valid[i_wr_idx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_hit     = r_valid[i_rd_idx] && (r_tag[i_rd_idx] == i_rd_tag);
    assign o_rd_data = r_data[i_rd_idx];
endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC, miss FSM and redirect handling around a
// direct-mapped instruction cache; presents one {pc, instruction} per cycle on hits.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int ICACHE_LINES_P = ICACHE_LINES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic        inst_valid,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_data,
    input  logic        dec_accept,
    input  logic        dec_redirect,
    input  logic [31:0] dec_redirect_addr,
    input  logic        rob_flush,
    input  logic [31:0] rob_flush_addr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_data,
    output logic        o_dbg_state
);
    localparam int IDX_W = $clog2(ICACHE_LINES_P);
    localparam int TAG_W = 30 - IDX_W;

    logic [31:0] r_pc;
    logic        r_state;
    logic        r_stale;

    logic             w_hit;
    logic [31:0]      w_line;
    logic             w_fill_en;
    logic             w_slot_free;
    logic             w_redirect;
    logic [31:0]      w_target;

    // Decoder handshake: an instruction transfers on a clock edge where
    // rdy && inst_valid && dec_accept and no redirect is sampled; inst_pc and
    // inst_data hold stable while inst_valid && !dec_accept.
    assign w_slot_free = !inst_valid || dec_accept;
    assign w_redirect  = rob_flush || dec_redirect;
    assign w_target    = (rob_flush ? rob_flush_addr : dec_redirect_addr) & ~32'h3;
    assign w_fill_en   = rdy && (r_state == ST_MISS) && mem_ready;
    assign o_dbg_state = r_state;

    inst_fetch_icache_array #(
        .LINES (ICACHE_LINES_P),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_icache (
        .clk       (clk),
        .rst       (rst),
        .i_rd_idx  (r_pc[IDX_W+1:2]),
        .i_rd_tag  (r_pc[31:IDX_W+2]),
        .o_hit     (w_hit),
        .o_rd_data (w_line),
        .i_wr_en   (w_fill_en),
        .i_wr_idx  (mem_addr[IDX_W+1:2]),
        .i_wr_tag  (mem_addr[31:IDX_W+2]),
        .i_wr_data (mem_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_state    <= ST_RUN;
            r_stale    <= 1'b0;
            inst_valid <= 1'b0;
            inst_pc    <= 32'h0;
            inst_data  <= 32'h0;
            mem_req    <= 1'b0;
            mem_addr   <= 32'h0;
        end else if (rdy) begin
            if (r_state == ST_RUN) begin
                if (w_redirect) begin
                    r_pc       <= w_target;
                    inst_valid <= 1'b0;
                end else if (w_slot_free) begin
                    if (w_hit) begin
                        inst_valid <= 1'b1;
                        inst_pc    <= r_pc;
                        inst_data  <= w_line;
                        r_pc       <= r_pc + 32'd4;
                    end else begin
                        inst_valid <= 1'b0;
                        mem_req    <= 1'b1;
                        mem_addr   <= {r_pc[31:2], 2'b00};
                        r_state    <= ST_MISS;
                    end
                end
            end else if (mem_ready) begin
                mem_req <= 1'b0;
                r_state <= ST_RUN;
                r_stale <= 1'b0;
                if (w_redirect) begin
                    r_pc       <= w_target;
                    inst_valid <= 1'b0;
                end else if (!r_stale) begin
                    inst_valid <= 1'b1;
                    inst_pc    <= mem_addr;
                    inst_data  <= mem_data;
                    r_pc       <= mem_addr + 32'd4;
                end
            end else if (w_redirect) begin
                // The outstanding request must complete; its fill is kept but not presented.
                r_pc       <= w_target;
                inst_valid <= 1'b0;
                r_stale    <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: memory model with fixed latency,
// consumption scoreboard, hand sequences for miss/redirect corners and a redirect table.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        dec_accept, dec_redirect, rob_flush;
    logic [31:0] dec_redirect_addr, rob_flush_addr;
    logic        mem_ready;
    logic [31:0] mem_data;
    logic        inst_valid, mem_req, dbg_state;
    logic [31:0] inst_pc, inst_data, mem_addr;

    int n_cmp  = 0;
    int n_err  = 0;
    int n_cons = 0;
    int mem_lat = 3;
    int mem_cnt = 0;
    logic [63:0] exp_q[$];

    typedef struct {
        logic        dec_r;
        logic [31:0] dec_a;
        logic        rob_f;
        logic [31:0] rob_a;
        logic [31:0] exp_pc;
    } redir_vec_t;
    redir_vec_t vecs [5];

    always #5 clk = ~clk;

    inst_fetch dut (
        .clk               (clk),
        .rst               (rst),
        .rdy               (rdy),
        .inst_valid        (inst_valid),
        .inst_pc           (inst_pc),
        .inst_data         (inst_data),
        .dec_accept        (dec_accept),
        .dec_redirect      (dec_redirect),
        .dec_redirect_addr (dec_redirect_addr),
        .rob_flush         (rob_flush),
        .rob_flush_addr    (rob_flush_addr),
        .mem_req           (mem_req),
        .mem_addr          (mem_addr),
        .mem_ready         (mem_ready),
        .mem_data          (mem_data),
        .o_dbg_state       (dbg_state)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cons(input int target);
        for (int k = 0; k < 80 && n_cons < target; k++) step();
        check("wait_cons_done", 32'(n_cons >= target), 32'd1);
    endtask

    task automatic wait_req();
        for (int k = 0; k < 80 && !mem_req; k++) step();
        check("wait_req_done", 32'(mem_req), 32'd1);
    endtask

    task automatic settle();
        dec_accept = 1'b0;
        for (int k = 0; k < 80 && !(dbg_state == ST_RUN && inst_valid); k++) step();
        check("settle_done", 32'(dbg_state == ST_RUN && inst_valid), 32'd1);
    endtask

    task automatic redirect(input logic [31:0] a);
        dec_redirect      = 1'b1;
        dec_redirect_addr = a;
        step();
        dec_redirect      = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] a);
        exp_q.push_back({a, mem_word(a)});
    endtask

    // Memory controller: answers a held request after mem_lat cycles with a one-cycle pulse.
    initial begin
        mem_ready = 1'b0;
        mem_data  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
            if (!mem_req) mem_cnt = 0;
            else begin
                mem_cnt++;
                if (mem_cnt >= mem_lat) begin
                    mem_ready = 1'b1;
                    mem_data  = mem_word(mem_addr);
                    mem_cnt   = 0;
                end
            end
        end
    end

    // Scoreboard: compare every instruction the decoder actually takes.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst && rdy && inst_valid && dec_accept && !dec_redirect && !rob_flush) begin
            n_cons++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_unexpected: got pc=%h data=%h, required no instruction", inst_pc, inst_data);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc", inst_pc, e[63:32]);
                check("sb_data", inst_data, e[31:0]);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [31:0] nxt;
        rst = 1'b1; rdy = 1'b1; dec_accept = 1'b0;
        dec_redirect = 1'b0; dec_redirect_addr = 32'h0;
        rob_flush = 1'b0; rob_flush_addr = 32'h0;

        vecs[0] = '{1'b1, 32'h0000_0080, 1'b1, 32'h0000_0200, 32'h0000_0200};
        vecs[1] = '{1'b1, 32'h0000_0087, 1'b0, 32'hDEAD_0000, 32'h0000_0084};
        vecs[2] = '{1'b0, 32'h0000_0999, 1'b1, 32'h0000_0302, 32'h0000_0300};
        vecs[3] = '{1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0000_0000, 32'hFFFF_FFFC};
        vecs[4] = '{1'b1, 32'h0000_0010, 1'b1, 32'h0000_0201, 32'h0000_0200};

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_pc", inst_pc, 32'h0);
        check("rst_data", inst_data, 32'h0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_state", 32'(dbg_state), 32'(ST_RUN));

        // Cold start: request for 0 held three cycles, instruction the cycle after mem_ready.
        rst = 1'b0;
        dec_accept = 1'b1;
        for (int i = 0; i < 8; i++) push_exp(32'(i * 4));
        for (int i = 0; i < 3; i++) begin
            step();
            check("cold_req", 32'(mem_req), 32'd1);
            check("cold_addr", mem_addr, 32'h0);
        end
        step();
        check("cold_req_drop", 32'(mem_req), 32'd0);
        check("cold_valid", 32'(inst_valid), 32'd1);
        check("cold_pc", inst_pc, 32'h0);
        check("cold_data", inst_data, 32'h0000_0013);
        step();
        check("cold_next_req", 32'(mem_req), 32'd1);
        check("cold_next_addr", mem_addr, 32'h4);
        wait_cons(8);

        // Stall hold on the 0x20 fill, then an rdy=0 freeze that ignores accept and flush.
        settle();
        check("hold_pc0", inst_pc, 32'h20);
        for (int i = 0; i < 4; i++) begin
            step();
            check("hold_valid", 32'(inst_valid), 32'd1);
            check("hold_pc", inst_pc, 32'h20);
            check("hold_data", inst_data, mem_word(32'h20));
            check("hold_req", 32'(mem_req), 32'd0);
        end
        rdy = 1'b0; dec_accept = 1'b1; rob_flush = 1'b1; rob_flush_addr = 32'h300;
        for (int i = 0; i < 2; i++) begin
            step();
            check("frz_valid", 32'(inst_valid), 32'd1);
            check("frz_pc", inst_pc, 32'h20);
            check("frz_req", 32'(mem_req), 32'd0);
        end
        rdy = 1'b1; rob_flush = 1'b0; dec_accept = 1'b0;

        // Hit streaming from 0: one instruction per cycle, no memory traffic.
        redirect(32'h0);
        dec_accept = 1'b1;
        for (int i = 0; i < 8; i++) push_exp(32'(i * 4));
        for (int i = 0; i < 9; i++) begin
            step();
            check("hit_valid", 32'(inst_valid), 32'd1);
            check("hit_pc", inst_pc, 32'(i * 4));
            check("hit_req", 32'(mem_req), 32'd0);
            if (i == 8) dec_accept = 1'b0;
        end

        // Redirect two cycles before mem_ready: 0x100 is filled silently, then 0x40 is fetched.
        redirect(32'h100);
        wait_req();
        check("stale_addr", mem_addr, 32'h100);
        dec_redirect = 1'b1; dec_redirect_addr = 32'h40;
        step();
        dec_redirect = 1'b0;
        check("stale_req_held", 32'(mem_req), 32'd1);
        check("stale_addr_held", mem_addr, 32'h100);
        check("stale_state", 32'(dbg_state), 32'(ST_MISS));
        step();
        check("stale_req_held2", 32'(mem_req), 32'd1);
        base = n_cons;
        push_exp(32'h40);
        dec_accept = 1'b1;
        step();
        check("stale_fill_req", 32'(mem_req), 32'd0);
        check("stale_fill_valid", 32'(inst_valid), 32'd0);
        check("stale_fill_state", 32'(dbg_state), 32'(ST_RUN));
        step();
        check("stale_next_req", 32'(mem_req), 32'd1);
        check("stale_next_addr", mem_addr, 32'h40);
        wait_cons(base + 1);
        settle();

        // Redirect in the same cycle as mem_ready: fill kept, nothing presented, go to target.
        redirect(32'h504);
        wait_req();
        check("same_addr", mem_addr, 32'h504);
        step();
        step();
        dec_redirect = 1'b1; dec_redirect_addr = 32'h40;
        step();
        dec_redirect = 1'b0;
        check("same_req", 32'(mem_req), 32'd0);
        check("same_valid", 32'(inst_valid), 32'd0);
        check("same_state", 32'(dbg_state), 32'(ST_RUN));
        step();
        check("same_hit_valid", 32'(inst_valid), 32'd1);
        check("same_hit_pc", inst_pc, 32'h40);
        check("same_hit_req", 32'(mem_req), 32'd0);
        redirect(32'h504);
        step();
        check("kept_valid", 32'(inst_valid), 32'd1);
        check("kept_pc", inst_pc, 32'h504);
        check("kept_data", inst_data, mem_word(32'h504));
        check("kept_req", 32'(mem_req), 32'd0);

        // Aliasing: 0x100 (filled while stale) evicted 0x0 at index 0.
        redirect(32'h100);
        step();
        check("alias_hit_pc", inst_pc, 32'h100);
        check("alias_hit_data", inst_data, mem_word(32'h100));
        check("alias_hit_req", 32'(mem_req), 32'd0);
        redirect(32'h0);
        step();
        check("alias_miss_req", 32'(mem_req), 32'd1);
        check("alias_miss_addr", mem_addr, 32'h0);

        // Reset during the outstanding miss drops the request immediately.
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_req", 32'(mem_req), 32'd0);
        check("rst_mid_valid", 32'(inst_valid), 32'd0);
        check("rst_mid_state", 32'(dbg_state), 32'(ST_RUN));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        base = n_cons;
        push_exp(32'h0);
        dec_accept = 1'b1;
        step();
        check("post_rst_req", 32'(mem_req), 32'd1);
        check("post_rst_addr", mem_addr, 32'h0);
        wait_cons(base + 1);
        settle();
        redirect(32'h20);
        step();
        check("post_rst_cleared_req", 32'(mem_req), 32'd1);
        check("post_rst_cleared_addr", mem_addr, 32'h20);
        settle();

        // Redirect table: priority, alignment and PC wrap.
        for (int v = 0; v < 5; v++) begin
            dec_redirect      = vecs[v].dec_r;
            dec_redirect_addr = vecs[v].dec_a;
            rob_flush         = vecs[v].rob_f;
            rob_flush_addr    = vecs[v].rob_a;
            step();
            dec_redirect = 1'b0;
            rob_flush    = 1'b0;
            nxt = vecs[v].exp_pc + 32'd4;
            push_exp(vecs[v].exp_pc);
            push_exp(nxt);
            base = n_cons;
            dec_accept = 1'b1;
            wait_cons(base + 2);
            settle();
        end

        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
